// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: top-level sequencer for the AES core.
// Accepts init/next commands while idle, issues one-cycle start pulses to the
// key memory and the encipher/decipher round blocks, owns the shared S-box
// select, and raises result capture/valid when a block finishes. A watchdog
// returns the controller to idle with a sticky error if a datapath block
// never reports ready.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   init         start key expansion (sampled in IDLE, priority over next)
//   next         start block operation (sampled in IDLE)
//   encdec       1=encipher, 0=decipher; sampled with next
//   key_init     one-cycle start pulse to key memory
//   key_ready    key memory ready
//   enc_next     one-cycle start pulse to encipher block
//   enc_ready    encipher block ready
//   dec_next     one-cycle start pulse to decipher block
//   dec_ready    decipher block ready
//   sbox_sel     shared S-box owner: 0=key memory, 1=encipher block
//   result_we    one-cycle capture strobe for result register
//   ready        controller idle, accepts commands
//   result_valid result register holds a valid block
//   error        sticky: timeout or next without a valid key
module aes_core_ctrl #(
    parameter logic [15:0] WDOG_CYCLES = 16'd1024
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic next,
    input  logic encdec,
    output logic key_init,
    input  logic key_ready,
    output logic enc_next,
    input  logic enc_ready,
    output logic dec_next,
    input  logic dec_ready,
    output logic sbox_sel,
    output logic result_we,
    output logic ready,
    output logic result_valid,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_PULSE = 3'd1,
        KEY_WAIT  = 3'd2,
        BLK_PULSE = 3'd3,
        BLK_WAIT  = 3'd4
    } state_t;

    // Last wait cycle before timeout, and the saturation ceiling of the counter.
    localparam logic [15:0] WDOG_LAST = WDOG_CYCLES - 16'd1;
    localparam logic [15:0] WDOG_MAX  = 16'hFFFF;

    state_t      state;
    logic        key_valid;
    logic        mode;
    logic [15:0] wdog_ctr;

    logic blk_ready_c;
    logic wdog_expired_c;

    // Completion is keyed only on the ready of the block that was started.
    assign blk_ready_c    = mode ? enc_ready : dec_ready;
    assign wdog_expired_c = (wdog_ctr == WDOG_LAST);

    // Sequencer with registered outputs; start pulses and result_we default
    // low every cycle so they last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            key_init     <= 1'b0;
            enc_next     <= 1'b0;
            dec_next     <= 1'b0;
            sbox_sel     <= 1'b0;
            result_we    <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            key_valid    <= 1'b0;
            mode         <= 1'b0;
            wdog_ctr     <= 16'd0;
        end else begin
            key_init  <= 1'b0;
            enc_next  <= 1'b0;
            dec_next  <= 1'b0;
            result_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (init) begin
                        state        <= KEY_PULSE;
                        ready        <= 1'b0;
                        result_valid <= 1'b0;
                        error        <= 1'b0;
                        key_valid    <= 1'b0;
                        key_init     <= 1'b1;
                        sbox_sel     <= 1'b0;
                    end else if (next) begin
                        if (key_valid) begin
                            state        <= BLK_PULSE;
                            mode         <= encdec;
                            ready        <= 1'b0;
                            result_valid <= 1'b0;
                            sbox_sel     <= 1'b1;
                            enc_next     <= encdec;
                            dec_next     <= ~encdec;
                        end else begin
                            // No key loaded: refuse the block and flag it.
                            error <= 1'b1;
                        end
                    end
                end

                KEY_PULSE: begin
                    wdog_ctr <= 16'd0;
                    state    <= KEY_WAIT;
                end

                KEY_WAIT: begin
                    if (key_ready) begin
                        key_valid <= 1'b1;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end else if (wdog_expired_c) begin
                        error     <= 1'b1;
                        key_valid <= 1'b0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end else if (wdog_ctr != WDOG_MAX) begin
                        wdog_ctr <= wdog_ctr + 16'd1;
                    end
                end

                BLK_PULSE: begin
                    wdog_ctr <= 16'd0;
                    state    <= BLK_WAIT;
                end

                BLK_WAIT: begin
                    if (blk_ready_c) begin
                        result_we    <= 1'b1;
                        result_valid <= 1'b1;
                        ready        <= 1'b1;
                        sbox_sel     <= 1'b0;
                        state        <= IDLE;
                    end else if (wdog_expired_c) begin
                        // Key stays valid: only the block operation failed.
                        error        <= 1'b1;
                        result_valid <= 1'b0;
                        sbox_sel     <= 1'b0;
                        ready        <= 1'b1;
                        state        <= IDLE;
                    end else if (wdog_ctr != WDOG_MAX) begin
                        wdog_ctr <= wdog_ctr + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Bench for aes_core_ctrl: one DUT at the default watchdog, one at WDOG_CYCLES=8.
// Start pulses and result strobes of the main DUT are matched against a queue
// of expected events pushed when the stimulus is driven.
module tb_aes_core_ctrl;

    localparam int P_KEY = 1;
    localparam int P_ENC = 2;
    localparam int P_DEC = 3;
    localparam int P_WE  = 4;

    logic clk = 1'b0;
    logic reset;

    logic init, next, encdec, key_ready, enc_ready, dec_ready;
    logic key_init, enc_next, dec_next, sbox_sel, result_we, ready, result_valid, error;

    logic w_init, w_next, w_encdec, w_key_ready, w_enc_ready, w_dec_ready;
    logic w_key_init, w_enc_next, w_dec_next, w_sbox_sel, w_result_we, w_ready;
    logic w_result_valid, w_error;

    int checks = 0;
    int errors = 0;
    int sb_q[$];
    logic [3:0] mon_pulses;
    int mon_exp;

    always #5 clk = ~clk;

    aes_core_ctrl dut (
        .clk(clk), .reset(reset), .init(init), .next(next), .encdec(encdec),
        .key_init(key_init), .key_ready(key_ready),
        .enc_next(enc_next), .enc_ready(enc_ready),
        .dec_next(dec_next), .dec_ready(dec_ready),
        .sbox_sel(sbox_sel), .result_we(result_we), .ready(ready),
        .result_valid(result_valid), .error(error)
    );

    aes_core_ctrl #(.WDOG_CYCLES(16'd8)) dut_wd (
        .clk(clk), .reset(reset), .init(w_init), .next(w_next), .encdec(w_encdec),
        .key_init(w_key_init), .key_ready(w_key_ready),
        .enc_next(w_enc_next), .enc_ready(w_enc_ready),
        .dec_next(w_dec_next), .dec_ready(w_dec_ready),
        .sbox_sel(w_sbox_sel), .result_we(w_result_we), .ready(w_ready),
        .result_valid(w_result_valid), .error(w_error)
    );

    // Scoreboard: every pulse on the main DUT must match the next expected event.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon_pulses = {result_we, dec_next, enc_next, key_init};
            for (int k = 0; k < 4; k++) begin
                if (mon_pulses[k] === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: pulse code %0d seen, required none", k + 1);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        if (mon_exp != k + 1) begin
                            errors++;
                            $display("FAIL sb_order: pulse code %0d seen, required %0d", k + 1, mon_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a key on the main DUT with key_ready low for low_cycles wait cycles.
    task automatic load_key(input int low_cycles);
        int n;
        init = 1'b1;
        sb_q.push_back(P_KEY);
        tick();
        init = 1'b0;
        key_ready = 1'b0;
        repeat (low_cycles) tick();
        key_ready = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL load_key_timeout: ready=%b required 1", ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #3;
        checks++;
        if ({ready, key_init, enc_next, dec_next, sbox_sel, result_we, result_valid, error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 10000000",
                     {ready, key_init, enc_next, dec_next, sbox_sel, result_we, result_valid, error});
        end
        checks++;
        if ({w_ready, w_key_init, w_enc_next, w_dec_next, w_sbox_sel, w_result_we, w_result_valid, w_error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs_wd: got %b required 10000000",
                     {w_ready, w_key_init, w_enc_next, w_dec_next, w_sbox_sel, w_result_we, w_result_valid, w_error});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b error=%b required 1 0", ready, error);
        end
    endtask

    task automatic test_key_load();
        int low_cycles;
        init = 1'b1;
        sb_q.push_back(P_KEY);
        tick();
        init = 1'b0;
        key_ready = 1'b0;
        checks++;
        if (key_init !== 1'b1 || sbox_sel !== 1'b0) begin
            errors++;
            $display("FAIL key_pulse: key_init=%b sbox_sel=%b required 1 0", key_init, sbox_sel);
        end
        low_cycles = 0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 12) key_ready = 1'b1;
            if (ready === 1'b0) low_cycles++;
            if (c < 13) tick();
        end
        checks++;
        if (low_cycles != 12) begin
            errors++;
            $display("FAIL key_busy_cycles: got %0d required 12", low_cycles);
        end
        checks++;
        if (ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL key_done: ready=%b error=%b required 1 0", ready, error);
        end
    endtask

    task automatic test_encipher();
        int bad;
        encdec = 1'b1;
        next = 1'b1;
        sb_q.push_back(P_ENC);
        tick();
        next = 1'b0;
        enc_ready = 1'b0;
        checks++;
        if (enc_next !== 1'b1 || sbox_sel !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL enc_pulse: enc_next=%b sbox_sel=%b ready=%b required 1 1 0", enc_next, sbox_sel, ready);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sbox_sel !== 1'b1 || ready !== 1'b0 || result_we !== 1'b0) bad++;
        end
        tick();
        enc_ready = 1'b1;
        sb_q.push_back(P_WE);
        checks++;
        if (bad != 0 || sbox_sel !== 1'b1) begin
            errors++;
            $display("FAIL enc_wait: bad_cycles=%0d sbox_sel=%b required 0 1", bad, sbox_sel);
        end
        tick();
        checks++;
        if ({result_we, result_valid, ready, sbox_sel} !== 4'b1110) begin
            errors++;
            $display("FAIL enc_done: we/valid/ready/sel=%b required 1110", {result_we, result_valid, ready, sbox_sel});
        end
        tick();
        checks++;
        if (result_we !== 1'b0 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL enc_hold: result_we=%b result_valid=%b required 0 1", result_we, result_valid);
        end
    endtask

    task automatic test_decipher();
        int bad;
        encdec = 1'b0;
        next = 1'b1;
        sb_q.push_back(P_DEC);
        tick();
        next = 1'b0;
        dec_ready = 1'b0;
        checks++;
        if (dec_next !== 1'b1 || sbox_sel !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL dec_pulse: dec_next=%b sbox_sel=%b result_valid=%b required 1 1 0",
                     dec_next, sbox_sel, result_valid);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            encdec = ~encdec;
            enc_ready = i[0];
            tick();
            if (sbox_sel !== 1'b1 || ready !== 1'b0 || result_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dec_ignores_enc: bad_cycles=%0d required 0", bad);
        end
        dec_ready = 1'b1;
        sb_q.push_back(P_WE);
        tick();
        checks++;
        if ({result_we, result_valid, ready, sbox_sel} !== 4'b1110) begin
            errors++;
            $display("FAIL dec_done: we/valid/ready/sel=%b required 1110", {result_we, result_valid, ready, sbox_sel});
        end
        encdec = 1'b0;
        enc_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        encdec = 1'b1;
        next = 1'b1;
        sb_q.push_back(P_ENC);
        tick();
        enc_ready = 1'b0;
        repeat (3) tick();
        enc_ready = 1'b1;
        sb_q.push_back(P_WE);
        tick();
        sb_q.push_back(P_ENC);
        checks++;
        if ({result_we, result_valid, ready} !== 3'b111) begin
            errors++;
            $display("FAIL b2b_done: we/valid/ready=%b required 111", {result_we, result_valid, ready});
        end
        tick();
        next = 1'b0;
        enc_ready = 1'b0;
        checks++;
        if ({enc_next, ready, result_valid} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_reaccept: enc_next/ready/valid=%b required 100", {enc_next, ready, result_valid});
        end
        repeat (2) tick();
        enc_ready = 1'b1;
        sb_q.push_back(P_WE);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1 || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: ready=%b result_valid=%b required 1 1", ready, result_valid);
        end
        tick();
    endtask

    task automatic test_no_key();
        int n;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        encdec = 1'b1;
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if ({error, ready, result_valid, sbox_sel} !== 4'b1100) begin
            errors++;
            $display("FAIL nokey_next: err/ready/valid/sel=%b required 1100", {error, ready, result_valid, sbox_sel});
        end
        tick();
        init = 1'b1;
        sb_q.push_back(P_KEY);
        tick();
        init = 1'b0;
        key_ready = 1'b0;
        checks++;
        if (error !== 1'b0 || key_init !== 1'b1) begin
            errors++;
            $display("FAIL nokey_init_clears: error=%b key_init=%b required 0 1", error, key_init);
        end
        repeat (2) tick();
        key_ready = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL nokey_reload: ready=%b error=%b required 1 0", ready, error);
        end
    endtask

    task automatic test_watchdog();
        int n;
        w_init = 1'b1;
        tick();
        w_init = 1'b0;
        w_key_ready = 1'b0;
        repeat (3) tick();
        w_key_ready = 1'b1;
        n = 0;
        while (w_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (w_ready !== 1'b1 || w_error !== 1'b0) begin
            errors++;
            $display("FAIL wd_key_load: ready=%b error=%b required 1 0", w_ready, w_error);
        end
        // Block timeout: count cycles from BLK_PULSE back to IDLE.
        w_encdec = 1'b1;
        w_next = 1'b1;
        tick();
        w_next = 1'b0;
        w_enc_ready = 1'b0;
        n = 0;
        while (w_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n - 1 != 8) begin
            errors++;
            $display("FAIL wd_blk_wait_cycles: got %0d required 8", n - 1);
        end
        checks++;
        if ({w_error, w_result_valid, w_sbox_sel, w_result_we, w_ready} !== 5'b10001) begin
            errors++;
            $display("FAIL wd_blk_timeout: err/valid/sel/we/ready=%b required 10001",
                     {w_error, w_result_valid, w_sbox_sel, w_result_we, w_ready});
        end
        // Key must still be valid after a block timeout.
        w_enc_ready = 1'b1;
        w_next = 1'b1;
        tick();
        w_next = 1'b0;
        w_enc_ready = 1'b0;
        checks++;
        if (w_enc_next !== 1'b1 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL wd_key_retained: enc_next=%b ready=%b required 1 0", w_enc_next, w_ready);
        end
        repeat (2) tick();
        w_enc_ready = 1'b1;
        n = 0;
        while (w_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (w_result_valid !== 1'b1 || w_error !== 1'b1) begin
            errors++;
            $display("FAIL wd_after_retry: result_valid=%b error=%b required 1 1", w_result_valid, w_error);
        end
        // Key-load timeout drops key_valid.
        w_init = 1'b1;
        tick();
        w_init = 1'b0;
        w_key_ready = 1'b0;
        n = 0;
        while (w_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n - 1 != 8 || w_error !== 1'b1) begin
            errors++;
            $display("FAIL wd_key_timeout: wait=%0d error=%b required 8 1", n - 1, w_error);
        end
        w_next = 1'b1;
        tick();
        w_next = 1'b0;
        w_key_ready = 1'b1;
        checks++;
        if (w_enc_next !== 1'b0 || w_ready !== 1'b1) begin
            errors++;
            $display("FAIL wd_key_dropped: enc_next=%b ready=%b required 0 1", w_enc_next, w_ready);
        end
        tick();
    endtask

    task automatic test_init_priority_reset();
        init = 1'b1;
        next = 1'b1;
        encdec = 1'b1;
        sb_q.push_back(P_KEY);
        tick();
        init = 1'b0;
        next = 1'b0;
        key_ready = 1'b0;
        checks++;
        if (key_init !== 1'b1 || enc_next !== 1'b0 || sbox_sel !== 1'b0) begin
            errors++;
            $display("FAIL prio_init: key_init=%b enc_next=%b sbox_sel=%b required 1 0 0", key_init, enc_next, sbox_sel);
        end
        repeat (2) tick();
        key_ready = 1'b1;
        repeat (2) tick();
        next = 1'b1;
        sb_q.push_back(P_ENC);
        tick();
        next = 1'b0;
        enc_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if (sbox_sel !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_in_wait: sbox_sel=%b ready=%b required 1 0", sbox_sel, ready);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ready, key_init, enc_next, dec_next, sbox_sel, result_we, result_valid, error} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL async_reset: got %b required 10000000",
                     {ready, key_init, enc_next, dec_next, sbox_sel, result_we, result_valid, error});
        end
        @(negedge clk);
        reset = 1'b0;
        enc_ready = 1'b1;
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if (error !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_clears_key: error=%b ready=%b required 1 1", error, ready);
        end
        repeat (2) tick();
    endtask

    initial begin
        init = 1'b0; next = 1'b0; encdec = 1'b0;
        key_ready = 1'b1; enc_ready = 1'b1; dec_ready = 1'b1;
        w_init = 1'b0; w_next = 1'b0; w_encdec = 1'b0;
        w_key_ready = 1'b1; w_enc_ready = 1'b1; w_dec_ready = 1'b1;

        test_reset();
        test_key_load();
        test_encipher();
        test_decipher();
        test_back_to_back();
        test_no_key();
        test_watchdog();
        test_init_priority_reset();
        load_key(1);
        repeat (2) tick();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected events never seen, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
